// File: rtl/rr_port_arbiter_if.sv
// Request/grant bundle between the input ports and one output-port arbiter.
// master drives requests and ready; slave is the arbiter.
interface rr_port_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 3
);
  localparam int IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid_i;
  logic [NUM_REQ*ADDR_W-1:0] req_nexthop_addr_i;
  logic [NUM_REQ-1:0]        req_tail_i;
  logic                      out_ready_i;
  logic [NUM_REQ-1:0]        grant_o;
  logic [IDX_W-1:0]          grant_idx_o;
  logic                      grant_valid_o;
  logic                      xfer_o;
  logic [IDX_W-1:0]          rr_ptr_o;
  logic                      timeout_o;

  modport master (
    output req_valid_i,
    output req_nexthop_addr_i,
    output req_tail_i,
    output out_ready_i,
    input  grant_o,
    input  grant_idx_o,
    input  grant_valid_o,
    input  xfer_o,
    input  rr_ptr_o,
    input  timeout_o
  );

  modport slave (
    input  req_valid_i,
    input  req_nexthop_addr_i,
    input  req_tail_i,
    input  out_ready_i,
    output grant_o,
    output grant_idx_o,
    output grant_valid_o,
    output xfer_o,
    output rr_ptr_o,
    output timeout_o
  );
endinterface

// File: rtl/rr_port_arbiter.sv
// Round-robin wormhole arbiter for one router output port.
// Optional stall timeout: define RR_LOCK_TIMEOUT_EN.
module rr_port_arbiter #(
  parameter int                NUM_REQ     = 4,
  parameter int                ADDR_W      = 3,
  parameter logic [ADDR_W-1:0] PORT_ID     = 3'd1,
  parameter int                TIMEOUT_CYC = 16
) (
  input logic         clk,
  input logic         reset,
  rr_port_arbiter_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [NUM_REQ-1:0]   r_grant, w_grant_nxt;
  logic [IDX_W-1:0]     r_idx, w_idx_nxt;
  logic [IDX_W-1:0]     r_ptr, w_ptr_nxt;
  logic                 r_timeout, w_timeout_nxt;

  logic [NUM_REQ-1:0]   w_desire;
  logic                 w_xfer;
  logic                 w_release;
  logic                 w_force;
  logic [IDX_W-1:0]     w_ptr_rel;
  logic [IDX_W:0]       w_pick_idle;
  logic [IDX_W:0]       w_pick_rel;

  // Returns {found, index}: first set bit scanning upward from p with wrap.
  function automatic logic [IDX_W:0] pick(
    input logic [NUM_REQ-1:0] d,
    input logic [IDX_W-1:0]   p
  );
    logic             f;
    logic [IDX_W-1:0] idx;
    int               k;
    f   = 1'b0;
    idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      k = (int'(p) + i) % NUM_REQ;
      if (d[k]) begin
        f   = 1'b1;
        idx = IDX_W'(k);
      end
    end
    return {f, idx};
  endfunction

  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      w_desire[k] = bus.req_valid_i[k] &
        (bus.req_nexthop_addr_i[k*ADDR_W +: ADDR_W] == PORT_ID);
    end
  end

  assign w_xfer = (r_state == LOCKED) &
                  bus.req_valid_i[r_idx] & bus.out_ready_i;

  assign w_ptr_rel = (r_idx == IDX_W'(NUM_REQ - 1)) ?
                     '0 : r_idx + 1'b1;

  assign w_pick_idle = pick(w_desire, r_ptr);
  assign w_pick_rel  = pick(w_desire & ~r_grant, w_ptr_rel);

  assign w_release = (w_xfer & bus.req_tail_i[r_idx]) | w_force;

`ifdef RR_LOCK_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] r_cnt;

  assign w_force = (r_state == LOCKED) & ~w_xfer &
                   (r_cnt == CNT_W'(TIMEOUT_CYC - 1));

  // Counts only uninterrupted stall cycles of the current packet.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (r_state != LOCKED || w_xfer || w_release) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end
`else
  assign w_force = 1'b0;
`endif

  always_comb begin
    w_state_nxt   = r_state;
    w_grant_nxt   = r_grant;
    w_idx_nxt     = r_idx;
    w_ptr_nxt     = r_ptr;
    w_timeout_nxt = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_pick_idle[IDX_W]) begin
          w_state_nxt = LOCKED;
          w_idx_nxt   = w_pick_idle[IDX_W-1:0];
          w_grant_nxt = NUM_REQ'(1) << w_pick_idle[IDX_W-1:0];
        end
      end
      LOCKED: begin
        if (w_release) begin
          w_ptr_nxt     = w_ptr_rel;
          w_timeout_nxt = w_force;
          if (w_pick_rel[IDX_W]) begin
            w_idx_nxt   = w_pick_rel[IDX_W-1:0];
            w_grant_nxt = NUM_REQ'(1) << w_pick_rel[IDX_W-1:0];
          end else begin
            w_state_nxt = IDLE;
            w_idx_nxt   = '0;
            w_grant_nxt = '0;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_grant   <= '0;
      r_idx     <= '0;
      r_ptr     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_grant   <= w_grant_nxt;
      r_idx     <= w_idx_nxt;
      r_ptr     <= w_ptr_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  assign bus.grant_o       = r_grant;
  assign bus.grant_idx_o   = r_idx;
  assign bus.grant_valid_o = (r_state == LOCKED);
  assign bus.xfer_o        = w_xfer;
  assign bus.rr_ptr_o      = r_ptr;
`ifdef RR_LOCK_TIMEOUT_EN
  assign bus.timeout_o     = r_timeout;
`else
  assign bus.timeout_o     = 1'b0;
`endif
endmodule

// File: tb/tb_rr_port_arbiter.sv
// Scoreboard bench for rr_port_arbiter: directed vectors queue
// expectations, a negedge monitor pops and compares.
module tb_rr_port_arbiter;
  logic clk;
  logic reset;
  int   cyc;
  int   n_vec;
  int   n_bad;

  rr_port_arbiter_if #(.NUM_REQ(4), .ADDR_W(3)) bus ();

  rr_port_arbiter #(
    .NUM_REQ(4),
    .ADDR_W(3),
    .PORT_ID(3'd1),
    .TIMEOUT_CYC(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  typedef struct {
    string      name;
    int         cyc;
    logic [3:0] g;
    logic       gv;
    logic [1:0] idx;
    logic [1:0] ptr;
    logic       x;
    logic       to;
  } exp_t;

  exp_t q[$];

  localparam logic [11:0] A_ALL1 = {3'd1, 3'd1, 3'd1, 3'd1};
  localparam logic [11:0] A_R0_2 = {3'd1, 3'd1, 3'd1, 3'd2};
  localparam logic [11:0] A_R1_2 = {3'd1, 3'd1, 3'd2, 3'd1};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic vec(
    input string      nm,
    input logic       rst,
    input logic [3:0] v,
    input logic [11:0] a,
    input logic [3:0] t,
    input logic       r,
    input logic [3:0] eg,
    input logic       egv,
    input logic [1:0] ei,
    input logic [1:0] ep,
    input logic       ex,
    input logic       eto
  );
    exp_t e;
    @(posedge clk);
    #1;
    reset                  = rst;
    bus.req_valid_i        = v;
    bus.req_nexthop_addr_i = a;
    bus.req_tail_i         = t;
    bus.out_ready_i        = r;
    e.name = nm;
    e.cyc  = cyc;
    e.g    = eg;
    e.gv   = egv;
    e.idx  = ei;
    e.ptr  = ep;
    e.x    = ex;
    e.to   = eto;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      n_vec++;
      if (e.cyc != cyc) begin
        n_bad++;
        $display("FAIL %s: stale vector (cycle %0d, now %0d)",
                 e.name, e.cyc, cyc);
      end else if (bus.grant_o !== e.g ||
                   bus.grant_valid_o !== e.gv ||
                   bus.grant_idx_o !== e.idx ||
                   bus.rr_ptr_o !== e.ptr ||
                   bus.xfer_o !== e.x ||
                   bus.timeout_o !== e.to) begin
        n_bad++;
        $display("FAIL %s: got g=%b gv=%b idx=%0d ptr=%0d x=%b to=%b want g=%b gv=%b idx=%0d ptr=%0d x=%b to=%b",
                 e.name, bus.grant_o, bus.grant_valid_o,
                 bus.grant_idx_o, bus.rr_ptr_o, bus.xfer_o,
                 bus.timeout_o, e.g, e.gv, e.idx, e.ptr, e.x, e.to);
      end
    end
  end

  initial begin
    n_vec = 0;
    n_bad = 0;
    reset                  = 1'b0;
    bus.req_valid_i        = '0;
    bus.req_nexthop_addr_i = '0;
    bus.req_tail_i         = '0;
    bus.out_ready_i        = 1'b0;

    vec("rst", 0, 4'b0000, A_ALL1, 4'b0000, 0, 4'b0000, 0, 0, 0, 0, 0);

    // 1: requesters 0 and 2 contend, 1-cycle grant latency
    vec("req02_idle", 1, 4'b0101, A_ALL1, 4'b0000, 0, 4'b0000, 0, 0, 0, 0, 0);
    vec("grant0", 1, 4'b0101, A_ALL1, 4'b0000, 0, 4'b0001, 1, 0, 0, 0, 0);
    // 2: 3-flit packet then zero-bubble handoff to 2
    vec("r0_f1", 1, 4'b0101, A_ALL1, 4'b0000, 1, 4'b0001, 1, 0, 0, 1, 0);
    vec("r0_f2", 1, 4'b0101, A_ALL1, 4'b0000, 1, 4'b0001, 1, 0, 0, 1, 0);
    vec("r0_tail", 1, 4'b0101, A_ALL1, 4'b0001, 1, 4'b0001, 1, 0, 0, 1, 0);
    vec("handoff2", 1, 4'b0100, A_ALL1, 4'b0100, 1, 4'b0100, 1, 2, 1, 1, 0);
    vec("idle_p3", 1, 4'b1000, A_ALL1, 4'b0000, 0, 4'b0000, 0, 0, 3, 0, 0);
    // 3: wrap 3 -> 0
    vec("grant3", 1, 4'b1001, A_ALL1, 4'b1000, 1, 4'b1000, 1, 3, 3, 1, 0);
    vec("wrap0", 1, 4'b0001, A_ALL1, 4'b0001, 1, 4'b0001, 1, 0, 0, 1, 0);
    vec("idle_p1", 1, 4'b0110, A_ALL1, 4'b0000, 0, 4'b0000, 0, 0, 1, 0, 0);
    // 4: stall on requester 1
    for (int i = 0; i < 5; i++) begin
      vec($sformatf("stall%0d", i), 1, 4'b0110, A_ALL1, 4'b0000, 0,
          4'b0010, 1, 1, 1, 0, 0);
    end
    vec("r1_tail", 1, 4'b0110, A_ALL1, 4'b0010, 1, 4'b0010, 1, 1, 1, 1, 0);
    vec("handoff2b", 1, 4'b0100, A_ALL1, 4'b0100, 1, 4'b0100, 1, 2, 2, 1, 0);
    // 5: wrong address never granted
    for (int i = 0; i < 3; i++) begin
      vec($sformatf("wrongaddr%0d", i), 1, 4'b0001, A_R0_2, 4'b0000, 1,
          4'b0000, 0, 0, 3, 0, 0);
    end
    vec("req1_p3", 1, 4'b0010, A_ALL1, 4'b0000, 0, 4'b0000, 0, 0, 3, 0, 0);
    vec("addr_chg_held", 1, 4'b0010, A_R1_2, 4'b0000, 1, 4'b0010, 1, 1, 3, 1, 0);
    vec("async_rst", 0, 4'b0010, A_ALL1, 4'b0000, 1, 4'b0000, 0, 0, 0, 0, 0);
    vec("rst_hold", 0, 4'b0010, A_ALL1, 4'b0000, 1, 4'b0000, 0, 0, 0, 0, 0);
    // 6: valid drop while locked on requester 1
    vec("req1_idle", 1, 4'b0010, A_ALL1, 4'b0000, 0, 4'b0000, 0, 0, 0, 0, 0);
`ifdef RR_LOCK_TIMEOUT_EN
    for (int i = 0; i < 16; i++) begin
      vec($sformatf("to_stall%0d", i), 1, 4'b0000, A_ALL1, 4'b0000, 1,
          4'b0010, 1, 1, 0, 0, 0);
    end
    vec("to_pulse", 1, 4'b0000, A_ALL1, 4'b0000, 1, 4'b0000, 0, 0, 2, 0, 1);
    vec("to_clear", 1, 4'b0000, A_ALL1, 4'b0000, 1, 4'b0000, 0, 0, 2, 0, 0);
`else
    for (int i = 0; i < 110; i++) begin
      vec($sformatf("hold%0d", i), 1, 4'b0000, A_ALL1, 4'b0000, 1,
          4'b0010, 1, 1, 0, 0, 0);
    end
`endif

    repeat (3) @(negedge clk);
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_vec++;
      n_bad++;
      $display("FAIL %s: never checked, got none want g=%b",
               e.name, e.g);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/rr_port_arbiter.md
Name: rr_port_arbiter

Overview:
- Parametrised round-robin arbiter for one router output port: one instance per output direction.
- Compares each requester's next-hop address against the port's own code and arbitrates among requesters targeting the port.
- Holds the grant for a whole packet (wormhole lock) until the tail flit transfers.
- Owns a rotating priority pointer, replacing the fixed one-hot priority registers, and exposes one-hot and encoded grants to the crossbar select.

Parameters:
- NUM_REQ, 4, number of requesting input ports (>=2).
- ADDR_W, 3, width of each next-hop address code.
- PORT_ID, 3'd1, next-hop code that selects this output port.
- TIMEOUT_CYC, 16, stall cycles before forced release (optional feature only; >=2).
- Localparam IDX_W = $clog2(NUM_REQ).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid_i  in  NUM_REQ  head/body flit present at requester k.
- req_nexthop_addr_i  in  NUM_REQ*ADDR_W  next-hop code of requester k; slice [k*ADDR_W +: ADDR_W].
- req_tail_i  in  NUM_REQ  current flit of requester k is the packet tail.
- out_ready_i  in  1  downstream accepts a flit this cycle.
- grant_o  out  NUM_REQ  one-hot grant, registered.
- grant_idx_o  out  IDX_W  encoded grant index for crossbar select.
- grant_valid_o  out  1  a grant is held (state LOCKED).
- xfer_o  out  1  flit transferred this cycle: grant_valid_o & req_valid_i[grant_idx_o] & out_ready_i.
- rr_ptr_o  out  IDX_W  current highest-priority requester index.
- timeout_o  out  1  one-cycle pulse on forced release (0 when the optional feature is out).

Behaviour:
- desire[k] = req_valid_i[k] & (addr slice k == PORT_ID). Combinational.
- Pick: first set desire[k] scanning k = rr_ptr, rr_ptr+1, ... mod NUM_REQ. Wrap-around is required; an index NUM_REQ-1 to 0 crossing has no gap.
- Reset (reset=0, async):
  - state = IDLE.
  - grant_o = 0, grant_idx_o = 0, grant_valid_o = 0.
  - rr_ptr_o = 0, timeout_o = 0.
- FSM IDLE:
  - If any desire: register the pick into grant_o/grant_idx_o and go to LOCKED.
  - Grant appears the cycle after the request (1-cycle latency).
  - Otherwise stay in IDLE.
- FSM LOCKED:
  - The grant is held regardless of the granted requester's address or valid drop; only req_valid_i and out_ready_i of the granted port matter.
  - Non-granted desires are ignored.
  - xfer_o with req_tail_i[grant_idx_o] = 1 causes release.
  - On release, rr_ptr updates to (grant_idx_o+1) mod NUM_REQ on the same edge.
- Release with re-arbitration (same edge):
  - The pick is recomputed using the updated pointer and the current desire vector with the releasing requester masked out.
  - If another requester wins, load the new grant and stay in LOCKED. This gives zero-bubble back-to-back packets.
  - If none wins, go to IDLE and clear the grant. The releasing requester can re-win from IDLE next cycle.
- Pointer changes only on release, never on a grant in IDLE.
- out_ready_i=0 or a granted valid=0 stalls the transfer; state and grant are unchanged.
- Single-flit packet (head is tail): lock and release span one transfer cycle.
- Reset asserted mid-packet: immediate return to the reset state; the partial packet is the upstream's concern.
- Outputs other than xfer_o are pure flops; xfer_o is combinational from flops and inputs.

Optional Feature:
- Macro: RR_LOCK_TIMEOUT_EN.
- Defined:
  - A stall counter, width $clog2(TIMEOUT_CYC+1), counts LOCKED cycles without xfer_o.
  - The counter clears on xfer_o, on leaving LOCKED, and on reset.
  - When it reaches TIMEOUT_CYC-1 and the current cycle also has no transfer: force release (pointer advance and re-arbitration exactly as for a tail release) and pulse timeout_o for one cycle.
- Undefined: no counter; timeout_o tied 0; the lock is held indefinitely.

Test Plan:
1. Reset, then requesters 0 and 2 both target PORT_ID=1 -> cycle+1 grant_o=4'b0001, grant_idx_o=0, rr_ptr_o=0.
2. Requester 0 sends a 3-flit packet with out_ready_i=1, requester 2 still waiting -> at the tail edge grant_o=4'b0100 with no IDLE cycle, rr_ptr_o=1.
3. Requester 3 locked, only requester 0 desires at the tail -> grant moves to 0, rr_ptr_o=0 (wrap from 3 to 0).
4. Locked on requester 1, out_ready_i=0 for 5 cycles while requester 2 desires -> grant_o stays 4'b0010, xfer_o=0, rr_ptr_o unchanged.
5. Requester with address 3'd2 (≠PORT_ID) and valid=1 -> never granted, grant_valid_o stays 0; reset pulsed mid-packet -> all outputs 0 asynchronously.
6. With RR_LOCK_TIMEOUT_EN and TIMEOUT_CYC=16, lock on requester 1 then hold valid=0 -> after the 16th stall cycle timeout_o pulses, the grant is released, rr_ptr_o=2; without the macro the grant is held past 100 cycles.
